aes_inv_cipher: RTL and testbench

Iterative AES-128 inverse cipher: accepts one 128-bit ciphertext block plus the final (round-10) round key over a valid/ready handshake. It runs the ten inverse rounds one per cycle, deriving each earlier round key on the fly by inverse key expansion, and returns the plaintext over a second valid/ready handshake. It is the decrypt-side counterpart of the encrypt round datapath and uses the same `[3:0][3:0][7:0]` state and key layout.

---
 rtl/aes_inv_cipher.sv | 166 ++++++++++++++++
 tb/tb_aes_inv_cipher.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher: one inverse round per enabled cycle, with the
// round keys walked backwards from the round-10 key by inverse key expansion.
module aes_inv_cipher (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0][3:0][7:0] ct,
  input  logic [3:0][3:0][7:0] last_key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0][3:0][7:0] pt
);

  typedef enum logic [1:0] {StIdle, StRound, StDone} fsm_e;

  fsm_e                 fsm;
  fsm_e                 fsm_next;
  logic [3:0][3:0][7:0] st;
  logic [3:0][3:0][7:0] rk;
  logic [3:0]           rnd;
  logic [3:0][3:0][7:0] prk;
  logic [3:0][3:0][7:0] sb;
  logic [3:0][3:0][7:0] mc;
  logic [3:0][7:0]      kw3;
  logic                 accept;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = x15;
    for (int i = 0; i < 4; i++) x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign accept = in_valid && in_ready;

  // Previous round key: undo the word chaining, then undo the SubWord/RotWord/Rcon term.
  always_comb begin
    kw3    = rk[3] ^ rk[2];
    prk    = rk;
    prk[3] = kw3;
    prk[2] = rk[2] ^ rk[1];
    prk[1] = rk[1] ^ rk[0];
    for (int r = 0; r < 4; r++) begin
      prk[0][r] = rk[0][r] ^ sbox(kw3[(r + 1) % 4]);
    end
    prk[0][0] = prk[0][0] ^ rcon(rnd);
  end

  // InvShiftRows + InvSubBytes + AddRoundKey, then InvMixColumns for the non-final rounds.
  always_comb begin
    sb = '0;
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sb[c][r] = inv_sbox(st[(c + 4 - r) % 4][r]) ^ prk[c][r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        mc[c][r] = gf_mul(8'h0e, sb[c][r])           ^ gf_mul(8'h0b, sb[c][(r + 1) % 4]) ^
                   gf_mul(8'h0d, sb[c][(r + 2) % 4]) ^ gf_mul(8'h09, sb[c][(r + 3) % 4]);
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= StIdle;
    else if (en) fsm <= fsm_next;
  end

  // Next-state logic; en gating is applied at the register.
  always_comb begin
    fsm_next = fsm;
    case (fsm)
      StIdle:  if (accept) fsm_next = StRound;
      StRound: if (rnd == 4'd1) fsm_next = StDone;
      StDone:  if (out_ready) fsm_next = StIdle;
      default: fsm_next = StIdle;
    endcase
  end

  // Handshake outputs depend only on fsm and en.
  always_comb begin
    in_ready  = (fsm == StIdle) && en;
    out_valid = (fsm == StDone);
  end

  // Datapath registers: load on accept, one inverse round per enabled ROUND cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= '0;
      rk  <= '0;
      rnd <= 4'd0;
      pt  <= '0;
    end else if (en) begin
      if (accept) begin
        st  <= ct ^ last_key;
        rk  <= last_key;
        rnd <= 4'd10;
      end else if (fsm == StRound) begin
        rk  <= prk;
        rnd <= rnd - 4'd1;
        if (rnd == 4'd1) pt <= sb;
        else st <= mc;
      end
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed bench for aes_inv_cipher using FIPS-197 C.1 and the all-zero-key vector.
module tb_aes_inv_cipher;

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0][3:0][7:0] ct;
  logic [3:0][3:0][7:0] last_key;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0][3:0][7:0] pt;

  int total;
  int bad;

  logic [3:0][3:0][7:0] c1_ct, c1_key, c1_pt, zk_ct, zk_key, zero_blk;

  aes_inv_cipher dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct        (ct),
    .last_key  (last_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt        (pt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hex string with in[0] first -> x[k/4][k%4].
  function automatic logic [3:0][3:0][7:0] conv(input logic [127:0] h);
    logic [3:0][3:0][7:0] x;
    for (int k = 0; k < 16; k++) x[k / 4][k % 4] = h[127 - 8 * k -: 8];
    return x;
  endfunction

  task automatic send(input logic [3:0][3:0][7:0] c, input logic [3:0][3:0][7:0] k);
    int w;
    @(negedge clk);
    ct = c;
    last_key = k;
    in_valid = 1'b1;
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_accept: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output int ir_err);
    lat = 0;
    ir_err = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (in_ready !== 1'b0) ir_err++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++;
    if (pt !== zero_blk) begin bad++; $display("FAIL reset_pt: got %h want 0", pt); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_c1;
    int lat, ire;
    out_ready = 1'b1;
    send(c1_ct, c1_key);
    wait_out(lat, ire);
    total++;
    if (lat !== 10) begin bad++; $display("FAIL c1_latency: got %0d want 10", lat); end
    total++;
    if (ire !== 0) begin bad++; $display("FAIL c1_in_ready_low: got %0d highs want 0", ire); end
    total++;
    if (pt !== c1_pt) begin bad++; $display("FAIL c1_pt: got %h want %h", pt, c1_pt); end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL c1_return_idle: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_zero_key;
    int lat, ire;
    out_ready = 1'b1;
    send(zk_ct, zk_key);
    wait_out(lat, ire);
    total++;
    if (lat !== 10) begin bad++; $display("FAIL zk_latency: got %0d want 10", lat); end
    total++;
    if (pt !== zero_blk) begin bad++; $display("FAIL zk_pt: got %h want 0", pt); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int lat, ire, err;
    out_ready = 1'b0;
    send(c1_ct, c1_key);
    wait_out(lat, ire);
    total++;
    if (lat !== 10) begin bad++; $display("FAIL bp_latency: got %0d want 10", lat); end
    err = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || pt !== c1_pt) err++;
    end
    total++;
    if (err !== 0) begin bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", err); end
    // en low in DONE: out_valid stays up, no transfer even with out_ready high.
    en = 1'b0;
    out_ready = 1'b1;
    err = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0) err++;
    end
    total++;
    if (err !== 0) begin bad++; $display("FAIL bp_en_low_hold: got %0d bad cycles want 0", err); end
    en = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    err = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) err++;
    end
    total++;
    if (err !== 0) begin bad++; $display("FAIL bp_single_transfer: got %0d extra valids want 0", err); end
    total++;
    if (pt !== c1_pt) begin bad++; $display("FAIL bp_pt_kept: got %h want %h", pt, c1_pt); end
  endtask

  task automatic test_stall;
    int lat, err;
    out_ready = 1'b1;
    send(zk_ct, zk_key);
    lat = 0;
    repeat (4) begin
      @(negedge clk);
      lat++;
    end
    en = 1'b0;
    err = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || pt !== c1_pt) err++;
    end
    en = 1'b1;
    total++;
    if (err !== 0) begin bad++; $display("FAIL stall_frozen: got %0d bad cycles want 0", err); end
    while (out_valid !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== 15) begin bad++; $display("FAIL stall_latency: got %0d want 15", lat); end
    total++;
    if (pt !== zero_blk) begin bad++; $display("FAIL stall_pt: got %h want 0", pt); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int lat, ire, err;
    out_ready = 1'b1;
    send(c1_ct, c1_key);
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || pt !== zero_blk || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_immediate: out_valid=%b pt=%h in_ready=%b want 0/0/1",
               out_valid, pt, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    err = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) err++;
    end
    total++;
    if (err !== 0) begin bad++; $display("FAIL rst_mid_no_pulse: got %0d valids want 0", err); end
    send(c1_ct, c1_key);
    wait_out(lat, ire);
    total++;
    if (lat !== 10 || pt !== c1_pt) begin
      bad++;
      $display("FAIL rst_mid_redo: lat=%0d pt=%h want 10 %h", lat, pt, c1_pt);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int na, no;
    int acc [2];
    logic [3:0][3:0][7:0] got [2];
    acc[0] = 0;
    acc[1] = 0;
    got[0] = '1;
    got[1] = '1;
    na = 0;
    no = 0;
    out_ready = 1'b1;
    @(negedge clk);
    ct = c1_ct;
    last_key = c1_key;
    in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (out_valid === 1'b1) begin
        if (no < 2) got[no] = pt;
        no++;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        if (na < 2) acc[na] = k;
        na++;
      end
      @(negedge clk);
      if (na == 1) begin
        ct = zk_ct;
        last_key = zk_key;
      end
      if (na >= 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    total++;
    if (na !== 2) begin bad++; $display("FAIL b2b_accepts: got %0d want 2", na); end
    total++;
    if (acc[1] - acc[0] !== 12) begin
      bad++;
      $display("FAIL b2b_interval: got %0d want 12", acc[1] - acc[0]);
    end
    total++;
    if (no !== 2) begin bad++; $display("FAIL b2b_outputs: got %0d want 2", no); end
    total++;
    if (got[0] !== c1_pt) begin bad++; $display("FAIL b2b_pt0: got %h want %h", got[0], c1_pt); end
    total++;
    if (got[1] !== zero_blk) begin bad++; $display("FAIL b2b_pt1: got %h want 0", got[1]); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    c1_ct    = conv(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    c1_key   = conv(128'h13111d7fe3944a17f307a78b4d2b30c5);
    c1_pt    = conv(128'h00112233445566778899aabbccddeeff);
    zk_ct    = conv(128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    zk_key   = conv(128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    zero_blk = '0;
    rst       = 1'b1;
    en        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ct        = '0;
    last_key  = '0;

    test_reset;
    test_c1;
    test_zero_key;
    test_backpressure;
    test_stall;
    test_reset_mid;
    test_back_to_back;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
